// File: rtl/sram_1rw_port_ctrl.sv
// sram_1rw_port_ctrl
// Schedules an independent write channel and read channel onto the single RW
// port of a 1-cycle-latency SRAM macro. Arbitration between the two channels
// is round-robin. Read data is captured into a 2-entry response queue.
// Read grants are throttled by a credit check, so the queue can never overflow.
//
// Optional feature: define SRAM_CTRL_RESP_BYPASS_EN to forward macro read data
// straight to the response port. Forwarding happens when the queue is empty and
// the consumer is ready, which gives a 1-cycle read latency. Without the macro,
// every response is registered and the read latency is 2 cycles.
module sram_1rw_port_ctrl #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 334
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_e;

  // Response queue storage: two slots addressed by a head pointer and an occupancy count.
  logic [DATA_W-1:0] slot_q [2];
  logic [DATA_W-1:0] slot_d [2];
  logic              head_q;
  logic              head_d;
  logic [1:0]        count_q;
  logic [1:0]        count_d;

  // A read was granted last cycle, so its data is on sram_rdata this cycle.
  logic              inflight_q;
  logic              inflight_d;

  // The channel that won the most recent grant. A tie goes to the other channel.
  grant_e            last_grant_q;
  grant_e            last_grant_d;

  logic              bypass_s;
  logic              q_pop_s;
  logic              q_push_s;
  logic              resp_take_s;
  logic [2:0]        credit_used_s;
  logic              rd_ok_s;
  logic              w_elig_s;
  logic              r_elig_s;
  logic              w_gnt_s;
  logic              r_gnt_s;
  logic              tail_s;

  // Response port: present the queue head, or forward live macro data when bypass is enabled.
  always_comb begin
    bypass_s   = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    q_pop_s    = 1'b0;
    if (count_q != 2'd0) begin
      resp_valid = 1'b1;
      resp_data  = slot_q[head_q];
      q_pop_s    = resp_ready;
    end else begin
`ifdef SRAM_CTRL_RESP_BYPASS_EN
      if (inflight_q && resp_ready) begin
        bypass_s   = 1'b1;
        resp_valid = 1'b1;
        resp_data  = sram_rdata;
      end else begin
        bypass_s   = 1'b0;
      end
`else
      bypass_s = 1'b0;
`endif
    end
    // Data that is forwarded directly is consumed on the spot and never enters the queue.
    q_push_s    = inflight_q && !bypass_s;
    resp_take_s = resp_valid && resp_ready;
  end

  // Credit check: queued responses plus the in-flight read, less any response
  // consumed this cycle, must leave room for one more read.
  always_comb begin
    credit_used_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, resp_take_s};
    rd_ok_s       = (credit_used_s < 3'd2);
  end

  // Round-robin arbitration. No channel is granted while reset is asserted.
  always_comb begin
    w_elig_s = reset_n && w_valid;
    r_elig_s = reset_n && r_valid && rd_ok_s;
    w_gnt_s  = 1'b0;
    r_gnt_s  = 1'b0;
    if (w_elig_s && r_elig_s) begin
      case (last_grant_q)
        GRANT_WRITE: r_gnt_s = 1'b1;
        GRANT_READ:  w_gnt_s = 1'b1;
        default:     r_gnt_s = 1'b1;
      endcase
    end else if (w_elig_s) begin
      w_gnt_s = 1'b1;
    end else if (r_elig_s) begin
      r_gnt_s = 1'b1;
    end else begin
      w_gnt_s = 1'b0;
      r_gnt_s = 1'b0;
    end
  end

  assign w_ready = w_gnt_s;
  assign r_ready = r_gnt_s;

  // Drive the macro port from the granted channel in the grant cycle. All macro outputs are 0 when idle.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = 1'b0;
    sram_wdata = '0;
    if (w_gnt_s) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = w_addr;
      sram_wmask = 1'b1;
      sram_wdata = w_data;
    end else if (r_gnt_s) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b0;
      sram_addr  = r_addr;
      sram_wmask = 1'b0;
      sram_wdata = w_data;
    end else begin
      sram_en    = 1'b0;
    end
  end

  // Next-state logic: push returning read data, pop on handshake, and track the in-flight read and the last winner.
  always_comb begin
    slot_d       = slot_q;
    head_d       = head_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    inflight_d   = r_gnt_s;
    // The pre-pop tail is correct even when a push and a pop happen together:
    // at count 1 the new entry lands opposite the head, and the head then moves onto it.
    tail_s       = head_q ^ count_q[0];

    if (q_push_s) begin
      slot_d[tail_s] = sram_rdata;
    end else begin
      slot_d[tail_s] = slot_q[tail_s];
    end

    if (q_pop_s) begin
      head_d = ~head_q;
    end else begin
      head_d = head_q;
    end

    case ({q_push_s, q_pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (w_gnt_s) begin
      last_grant_d = GRANT_WRITE;
    end else if (r_gnt_s) begin
      last_grant_d = GRANT_READ;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // State registers. Reset discards the queue contents and any in-flight read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_q[0]    <= '0;
      slot_q[1]    <= '0;
      head_q       <= 1'b0;
      count_q      <= 2'd0;
      inflight_q   <= 1'b0;
      last_grant_q <= GRANT_WRITE;
    end else begin
      slot_q       <= slot_d;
      head_q       <= head_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
